// File: rtl/fxp_addsub_pkg.sv
// Shared definitions for the fixed-point add/sub scheduler: op encodings,
// stage-B controller state encoding and saturation limit helpers.
package fxp_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    B_EMPTY = 1'b0,
    B_FULL  = 1'b1
  } b_state_e;

  // Largest value representable in Q(wi.wf), as a raw integer code.
  function automatic int sat_max(int wi, int wf);
    return (1 << (wi + wf - 1)) - 1;
  endfunction

  // Most negative value representable in Q(wi.wf), as a raw integer code.
  function automatic int sat_min(int wi, int wf);
    return -(1 << (wi + wf - 1));
  endfunction

endpackage

// File: rtl/fxp_addsub_scheduler_if.sv
// Request/result bus of the fixed-point add/sub scheduler.
//
// Handshake: on both the request side (per requester) and the result side a
// transfer happens on a rising clk edge where valid && ready are both 1.
// A source keeps valid and its payload stable until the transfer; a request
// may be withdrawn before acceptance, the result port never withdraws.
interface fxp_addsub_scheduler_if #(
  parameter int NREQ = 4,
  parameter int WI   = 4,
  parameter int WF   = 4
);
  localparam int W   = WI + WF;
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*W-1:0] req_in1;
  logic [NREQ*W-1:0] req_in2;
  logic              out_valid;
  logic              out_ready;
  logic [IDW-1:0]    out_id;
  logic [W:0]        out_result;
  logic              out_overflow;

  modport master (
    output req_valid, req_op, req_in1, req_in2, out_ready,
    input  req_ready, out_valid, out_id, out_result, out_overflow
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, out_ready,
    output req_ready, out_valid, out_id, out_result, out_overflow
  );
endinterface

// File: rtl/fxp_rr_arbiter.sv
// Round-robin arbiter: searches upward from rr_ptr, grants one requester
// when enabled, and moves the pointer just past the winner.
module fxp_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic [IDW-1:0]  rr_ptr
);

  logic           found;
  logic [IDW:0]   probe;
  logic [IDW-1:0] idx_c;

  // First requesting index at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    probe     = '0;
    idx_c     = '0;
    for (int k = 0; k < NREQ; k++) begin
      probe = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (probe >= (IDW+1)'(NREQ)) probe = probe - (IDW+1)'(NREQ);
      idx_c = probe[IDW-1:0];
      if (!found && req[idx_c]) begin
        found     = 1'b1;
        grant_idx = idx_c;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

  // Pointer advances past the winner on a grant, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (en && found) begin
      rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fxp_addsub_scheduler.sv
// Shares one two-stage fixed-point add/sub pipeline among NREQ requesters.
// Stage A holds the granted op/operands/ID, stage B the exact W+1 bit result.
// Optional macro FXP_ADDSUB_SATURATE_EN clamps overflowing results to the
// Q(WI.WF) limits (sign-extended to W+1 bits).
module fxp_addsub_scheduler
  import fxp_addsub_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WI   = 4,
  parameter int WF   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  fxp_addsub_scheduler_if.slave     bus,
  output b_state_e                  dbg_state,
  output logic [$clog2(NREQ)-1:0]   dbg_rr_ptr
);

  localparam int W   = WI + WF;
  localparam int IDW = $clog2(NREQ);

`ifdef FXP_ADDSUB_SATURATE_EN
  localparam logic [W:0] SAT_MAX = (W+1)'(sat_max(WI, WF));
  localparam logic [W:0] SAT_MIN = (W+1)'(sat_min(WI, WF));
`endif

  logic            a_valid;
  logic            a_op;
  logic [IDW-1:0]  a_id;
  logic [W-1:0]    a_in1;
  logic [W-1:0]    a_in2;
  b_state_e        b_state;
  logic [IDW-1:0]  b_id;
  logic [W:0]      b_result;
  logic            b_ovf;

  logic            b_adv;
  logic            a_adv;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [W:0]      ext1;
  logic [W:0]      ext2;
  logic [W:0]      sum_c;
  logic [W:0]      res_c;
  logic            ovf_c;

  assign bus.out_valid    = (b_state == B_FULL);
  assign bus.out_id       = b_id;
  assign bus.out_result   = b_result;
  assign bus.out_overflow = b_ovf;
  assign dbg_state        = b_state;

  assign b_adv     = !bus.out_valid || bus.out_ready;
  assign a_adv     = !a_valid || b_adv;
  assign grant_any = |grant;
  assign bus.req_ready = grant;

  fxp_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .en        (a_adv),
    .grant     (grant),
    .grant_idx (grant_idx),
    .rr_ptr    (dbg_rr_ptr)
  );

  // Stage A: capture the winning request whenever the stage can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_op    <= OP_ADD;
      a_id    <= '0;
      a_in1   <= '0;
      a_in2   <= '0;
    end else if (a_adv) begin
      a_valid <= grant_any;
      if (grant_any) begin
        a_op  <= bus.req_op[grant_idx];
        a_id  <= grant_idx;
        a_in1 <= bus.req_in1[grant_idx*W +: W];
        a_in2 <= bus.req_in2[grant_idx*W +: W];
      end
    end
  end

  // Exact add/sub on sign-extended operands; one extra bit means no wrap,
  // so negating the most negative operand is still exact.
  always_comb begin
    ext1  = {a_in1[W-1], a_in1};
    ext2  = {a_in2[W-1], a_in2};
    sum_c = (a_op == OP_SUB) ? (ext1 - ext2) : (ext1 + ext2);
    ovf_c = sum_c[W] ^ sum_c[W-1];
    res_c = sum_c;
`ifdef FXP_ADDSUB_SATURATE_EN
    if (ovf_c) res_c = sum_c[W] ? SAT_MIN : SAT_MAX;
`endif
  end

  // Stage B controller and result registers (out_valid is the FULL state).
  always_ff @(posedge clk) begin
    if (rst) begin
      b_state  <= B_EMPTY;
      b_id     <= '0;
      b_result <= '0;
      b_ovf    <= 1'b0;
    end else begin
      case (b_state)
        B_EMPTY: if (a_valid) b_state <= B_FULL;
        B_FULL:  if (bus.out_ready) b_state <= a_valid ? B_FULL : B_EMPTY;
        default: b_state <= B_EMPTY;
      endcase
      if (b_adv && a_valid) begin
        b_id     <= a_id;
        b_result <= res_c;
        b_ovf    <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_fxp_addsub_scheduler.sv
// Self-checking bench for fxp_addsub_scheduler (NREQ=4, Q4.4 operands).
// Reference: integer arithmetic on operand values, a round-robin pointer and
// an expected-result queue whose length stands for pipeline occupancy.
module tb_fxp_addsub_scheduler;
  import fxp_addsub_pkg::*;

  localparam int NREQ = 4;
  localparam int WI   = 4;
  localparam int WF   = 4;
  localparam int W    = WI + WF;
  localparam int IDW  = 2;
  localparam int EW   = IDW + 1 + W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fxp_addsub_scheduler_if #(.NREQ(NREQ), .WI(WI), .WF(WF)) bus ();
  b_state_e       dbg_state;
  logic [IDW-1:0] dbg_rr_ptr;

  fxp_addsub_scheduler #(.NREQ(NREQ), .WI(WI), .WF(WF)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- scoreboard state ----------------
  int             n_checks = 0;
  int             n_pass   = 0;
  int             cyc      = 0;
  int             m_ptr    = 0;
  logic [EW-1:0]  exp_q[$];
  int             exp_t[$];
  int             out_log[$];
  int             last_grant = -1;

  // Expected {id, overflow, result} from the operand values.
  function automatic logic [EW-1:0] ref_entry(int id, logic op, logic [W-1:0] in1, logic [W-1:0] in2);
    int a, b, r, lim_hi, lim_lo;
    logic ovf;
    logic [W:0] res;
    a = int'($signed(in1));
    b = int'($signed(in2));
    r = op ? (a - b) : (a + b);
    lim_hi = (1 << (W - 1)) - 1;
    lim_lo = -(1 << (W - 1));
    ovf = (r > lim_hi) || (r < lim_lo);
`ifdef FXP_ADDSUB_SATURATE_EN
    if (r > lim_hi) r = lim_hi;
    if (r < lim_lo) r = lim_lo;
`endif
    res = r[W:0];
    return {IDW'(id), ovf, res};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return 8'h80;
      1:       return 8'h7F;
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- driver: one clock with scoreboard ----------------
  task automatic cycle();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_ov;
    bit              can;
    int              g, idx;
    #1;
    last_grant = -1;
    if (!rst) begin
      can     = (exp_q.size() < 2) || bus.out_ready;
      exp_rdy = '0;
      g       = -1;
      if (can) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      n_checks++;
      if (bus.req_ready !== exp_rdy)
        $display("FAIL req_ready cyc=%0d got %b expected %b", cyc, bus.req_ready, exp_rdy);
      else n_pass++;

      exp_ov = (exp_q.size() > 0) && (cyc >= exp_t[0] + 2);
      n_checks++;
      if (bus.out_valid !== exp_ov)
        $display("FAIL out_valid cyc=%0d got %b expected %b", cyc, bus.out_valid, exp_ov);
      else n_pass++;
      if (exp_ov) begin
        n_checks++;
        if ({bus.out_id, bus.out_overflow, bus.out_result} !== exp_q[0])
          $display("FAIL out_payload cyc=%0d got id=%0d ovf=%b res=%h expected id=%0d ovf=%b res=%h",
                   cyc, bus.out_id, bus.out_overflow, bus.out_result,
                   exp_q[0][EW-1 -: IDW], exp_q[0][W+1], exp_q[0][W:0]);
        else n_pass++;
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_t.pop_front());
        end
      end
      if (bus.out_valid && bus.out_ready) out_log.push_back(int'(bus.out_id));

      if (g >= 0) begin
        exp_q.push_back(ref_entry(g, bus.req_op[g], bus.req_in1[g*W +: W], bus.req_in2[g*W +: W]));
        exp_t.push_back(cyc);
        m_ptr      = (g + 1) % NREQ;
        last_grant = g;
      end
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_t.delete();
      m_ptr = 0;
    end
    #1;
  endtask

  task automatic set_req(int i, logic op, logic [W-1:0] in1, logic [W-1:0] in2);
    bus.req_op[i]          = op;
    bus.req_in1[i*W +: W]  = in1;
    bus.req_in2[i*W +: W]  = in2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++;
    if (bus.out_result !== '0) $display("FAIL reset_out_result got %h expected 000", bus.out_result); else n_pass++;
    n_checks++;
    if (bus.out_id !== '0) $display("FAIL reset_out_id got %0d expected 0", bus.out_id); else n_pass++;
    n_checks++;
    if (bus.out_overflow !== 1'b0) $display("FAIL reset_out_overflow got %b expected 0", bus.out_overflow); else n_pass++;
    n_checks++;
    if (dbg_rr_ptr !== '0) $display("FAIL reset_rr_ptr got %0d expected 0", dbg_rr_ptr); else n_pass++;
    n_checks++;
    if (dbg_state !== B_EMPTY) $display("FAIL reset_state got %0d expected 0", dbg_state); else n_pass++;
  endtask

  task automatic test_directed();
    int         ids[5]  = '{0, 1, 2, 2, 3};
    logic       ops[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] a1[5]   = '{8'h38, 8'h78, 8'h80, 8'h00, 8'h80};
    logic [7:0] a2[5]   = '{8'hDC, 8'h10, 8'h10, 8'h80, 8'h80};
`ifdef FXP_ADDSUB_SATURATE_EN
    logic [8:0] er[5]   = '{9'h05C, 9'h07F, 9'h180, 9'h07F, 9'h180};
`else
    logic [8:0] er[5]   = '{9'h05C, 9'h088, 9'h170, 9'h080, 9'h100};
`endif
    logic       eo[5]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      bus.req_valid = '0;
      set_req(ids[t], ops[t], a1[t], a2[t]);
      bus.req_valid[ids[t]] = 1'b1;
      cycle();
      n_checks++;
      if (last_grant !== ids[t]) $display("FAIL dir%0d_grant got %0d expected %0d", t, last_grant, ids[t]); else n_pass++;
      bus.req_valid = '0;
      cycle();
      n_checks++;
      if (bus.out_valid !== 1'b1) $display("FAIL dir%0d_latency got out_valid=%b expected 1", t, bus.out_valid); else n_pass++;
      n_checks++;
      if (bus.out_result !== er[t]) $display("FAIL dir%0d_result got %h expected %h", t, bus.out_result, er[t]); else n_pass++;
      n_checks++;
      if (bus.out_overflow !== eo[t]) $display("FAIL dir%0d_overflow got %b expected %b", t, bus.out_overflow, eo[t]); else n_pass++;
      n_checks++;
      if (bus.out_id !== IDW'(ids[t])) $display("FAIL dir%0d_id got %0d expected %0d", t, bus.out_id, ids[t]); else n_pass++;
      cycle();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    out_log.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), rand_operand(), rand_operand());
    bus.req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      n_checks++;
      if (last_grant !== i % NREQ) $display("FAIL rr_grant%0d got %0d expected %0d", i, last_grant, i % NREQ); else n_pass++;
    end
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) cycle();
    n_checks++;
    if (out_log.size() !== 8) $display("FAIL rr_out_count got %0d expected 8", out_log.size()); else n_pass++;
    for (int i = 0; i < out_log.size() && i < 8; i++) begin
      n_checks++;
      if (out_log[i] !== i % NREQ) $display("FAIL rr_out_id%0d got %0d expected %0d", i, out_log[i], i % NREQ); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int             accepted = 0;
    logic [W:0]     hold_res = '0;
    logic [IDW-1:0] hold_id  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom), rand_operand(), rand_operand());
    bus.req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (last_grant >= 0) accepted++;
      if (i == 2) begin
        hold_res = bus.out_result;
        hold_id  = bus.out_id;
      end else if (i > 2) begin
        n_checks++;
        if (bus.out_result !== hold_res || bus.out_id !== hold_id)
          $display("FAIL bp_stable%0d got res=%h id=%0d expected res=%h id=%0d", i, bus.out_result, bus.out_id, hold_res, hold_id);
        else n_pass++;
      end
    end
    n_checks++;
    if (accepted !== 2) $display("FAIL bp_accepted got %0d expected 2", accepted); else n_pass++;
    n_checks++;
    if (bus.req_ready !== '0) $display("FAIL bp_ready_low got %b expected 0000", bus.req_ready); else n_pass++;
    out_log.delete();
    bus.out_ready = 1'b1;
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (out_log.size() !== 2) $display("FAIL bp_delivered got %0d expected 2", out_log.size()); else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL bp_pending got %0d expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.req_valid = '0;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++;
    if (dbg_rr_ptr !== '0) $display("FAIL rstmid_rr_ptr got %0d expected 0", dbg_rr_ptr); else n_pass++;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1010;
    cycle();
    n_checks++;
    if (last_grant !== 1) $display("FAIL rstmid_first_grant got %0d expected 1", last_grant); else n_pass++;
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || last_grant == i) begin
          bus.req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, 1'($urandom), rand_operand(), rand_operand());
        end else if ($urandom_range(0, 15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL rand_drain got %0d pending expected 0", exp_q.size()); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
